// File: rtl/video_pkg.sv
// video_pkg: shared capture FSM encoding and pixel width for the video capture path
package video_pkg;
    localparam int PIX_W = 24;
    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, DRAIN, DONE} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead single-clock FIFO; a push into a full FIFO succeeds only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout = mem[rd_ptr];
    // storage write; stale contents after flush are unreachable because the pointers reset
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    // pointer and occupancy tracking, flush empties the buffer in one cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(do_pop);
            wr_ptr <= wr_ptr + AW'(do_push);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: captures one HDMI frame into a pixel FIFO and streams it out as addressed writes
module frame_capture_ctrl import video_pkg::*; #(
    parameter int H_RES = 64,
    parameter int V_RES = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W = 12
) (
    input  logic              hdmi_clk,
    input  logic              rst_n,
    input  logic              hdmi_de,
    input  logic              hdmi_vs,
    input  logic              hdmi_hs,
    input  logic [7:0]        hdmi_r,
    input  logic [7:0]        hdmi_g,
    input  logic [7:0]        hdmi_b,
    input  logic              start,
    input  logic              abort,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              frame_err
);
    localparam int TOTAL = H_RES * V_RES;
    state_t state, nxt;
    logic vs_q, vs_fall, pix_in, last_pix, pop, full, empty, unused_hs;
    logic [ADDR_W-1:0] pix_cnt;
    assign unused_hs = hdmi_hs;
    assign vs_fall = vs_q & ~hdmi_vs;
    assign pix_in = (state == CAPTURE) && hdmi_de;
    assign last_pix = pix_cnt == ADDR_W'(TOTAL - 1);
    assign wr_valid = ((state == CAPTURE) || (state == DRAIN)) && !empty;
    assign pop = wr_valid && wr_ready;

    sync_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (hdmi_clk),
        .rst_n (rst_n),
        .push  (pix_in),
        .pop   (pop),
        .flush (abort),
        .din   ({hdmi_r, hdmi_g, hdmi_b}),
        .dout  (wr_data),
        .full  (full),
        .empty (empty)
    );

    // next-state selection; abort wins over every other condition
    always_comb begin
        nxt = state;
        if (abort) nxt = IDLE;
        else
            case (state)
                IDLE:    nxt = start ? ARM : IDLE;
                ARM:     nxt = vs_fall ? CAPTURE : ARM;
                CAPTURE: nxt = ((pix_in && last_pix) || vs_fall) ? DRAIN : CAPTURE;
                DRAIN:   nxt = empty ? DONE : DRAIN;
                default: nxt = IDLE;
            endcase
    end

    // state, registered status flags, vsync history and the pixel/address counters
    always_ff @(posedge hdmi_clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            vs_q <= 1'b1;
            overflow <= 1'b0;
            frame_err <= 1'b0;
            pix_cnt <= '0;
            wr_addr <= '0;
        end else begin
            state <= nxt;
            busy <= nxt != IDLE;
            done <= nxt == DONE;
            vs_q <= hdmi_vs;
            if (state == IDLE && start && !abort) begin
                overflow <= 1'b0;
                frame_err <= 1'b0;
                pix_cnt <= '0;
                wr_addr <= '0;
            end else begin
                if (pix_in) pix_cnt <= pix_cnt + ADDR_W'(1);
                if (pix_in && full && !pop) overflow <= 1'b1;
                if (state == CAPTURE && vs_fall && !abort && !(pix_in && last_pix)) frame_err <= 1'b1;
                if (pop) wr_addr <= wr_addr + ADDR_W'(1);
            end
        end
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: table vectors, directed corner sequences and randomized frames against a queue model
module tb_frame_capture_ctrl;
    localparam int H = 8, V = 4, D = 4, AW = 12, TOTAL = H * V;

    logic hdmi_clk = 1'b0;
    logic rst_n, hdmi_de, hdmi_vs, hdmi_hs, start, abort, wr_ready;
    logic [7:0] hdmi_r, hdmi_g, hdmi_b;
    logic wr_valid, busy, done, overflow, frame_err;
    logic [AW-1:0] wr_addr;
    logic [23:0] wr_data;

    int errors = 0, checks = 0, done_cnt = 0;
    int wa[$];
    logic [23:0] wd[$];
    bit stall_q = 0;
    logic [AW-1:0] stall_a;
    logic [23:0] stall_d;

    typedef struct {
        bit st, ab, vs, de, rdy;
        bit e_busy, e_valid, e_done;
    } vec_t;
    vec_t tbl[12];

    frame_capture_ctrl #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
        .hdmi_clk  (hdmi_clk),
        .rst_n     (rst_n),
        .hdmi_de   (hdmi_de),
        .hdmi_vs   (hdmi_vs),
        .hdmi_hs   (hdmi_hs),
        .hdmi_r    (hdmi_r),
        .hdmi_g    (hdmi_g),
        .hdmi_b    (hdmi_b),
        .start     (start),
        .abort     (abort),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 hdmi_clk = ~hdmi_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge hdmi_clk);
        #1;
    endtask

    // write monitor: records handshakes, counts done pulses, checks stability across stalls
    always @(posedge hdmi_clk) begin
        if (!rst_n) stall_q = 0;
        else begin
            if (stall_q && wr_valid) begin
                chk("stall_addr", 32'(wr_addr), 32'(stall_a));
                chk("stall_data", 32'(wr_data), 32'(stall_d));
            end
            if (wr_valid && wr_ready) begin
                wa.push_back(int'(wr_addr));
                wd.push_back(wr_data);
            end
            if (done) done_cnt++;
            stall_q = wr_valid && !wr_ready;
            stall_a = wr_addr;
            stall_d = wr_data;
        end
    end

    // one whole capture; the model is a bounded queue fed by DE pixels and drained by ready
    task automatic run_frame(input string name, input int n_pix, input int rmode, input bit rand_de);
        logic [23:0] q[$];
        logic [23:0] exp[$];
        logic [23:0] px;
        int cnt = 0, guard = 0;
        bit ovf = 0, ferr = 0, cap = 1, pop, acc;
        wa.delete();
        wd.delete();
        done_cnt = 0;
        start = 1; tick; start = 0;
        hdmi_de = 1; tick; tick;
        hdmi_de = 0; hdmi_vs = 0; tick; hdmi_vs = 1;
        while ((cap || q.size() > 0) && guard < 2000) begin
            guard++;
            px = 24'($urandom);
            {hdmi_r, hdmi_g, hdmi_b} = px;
            hdmi_de = rand_de ? 1'($urandom_range(0, 1)) : 1'b1;
            hdmi_vs = 1;
            if (cap && n_pix < TOTAL && cnt == n_pix) begin
                hdmi_vs = 0;
                hdmi_de = 0;
            end
            wr_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cnt >= H) : rmode == 2 ? 1'(guard & 1) : 1'($urandom_range(0, 1));
            pop = q.size() > 0 && wr_ready;
            acc = q.size() < D || pop;
            if (pop) exp.push_back(q.pop_front());
            if (cap) begin
                if (!hdmi_vs) begin
                    cap = 0;
                    ferr = 1;
                end else if (hdmi_de) begin
                    cnt++;
                    if (acc) q.push_back(px);
                    else ovf = 1;
                    if (cnt == TOTAL) cap = 0;
                end
            end
            tick;
        end
        wr_ready = 1; hdmi_de = 0; hdmi_vs = 1;
        for (int i = 0; i < 10; i++) tick;
        chk({name, "_in_budget"}, 32'(guard < 2000), 1);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_writes"}, wa.size(), exp.size());
        foreach (exp[i])
            if (i < wa.size()) begin
                chk({name, "_addr"}, wa[i], i);
                chk({name, "_data"}, 32'(wd[i]), 32'(exp[i]));
            end
        chk({name, "_overflow"}, 32'(overflow), 32'(ovf));
        chk({name, "_frame_err"}, 32'(frame_err), 32'(ferr));
        chk({name, "_done"}, done_cnt, 1);
    endtask

    initial begin
        rst_n = 0; start = 0; abort = 0; hdmi_de = 0; hdmi_vs = 1; hdmi_hs = 1; wr_ready = 0;
        {hdmi_r, hdmi_g, hdmi_b} = 24'h0;
        tick; tick;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(wr_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_addr", 32'(wr_addr), 0);
        rst_n = 1; tick;

        tbl[0]  = '{1, 0, 1, 0, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 0, 1, 0, 0};
        tbl[2]  = '{1, 0, 1, 1, 0, 1, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 1, 0, 0, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 1, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 1, 0, 0, 1, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 0, 0, 0, 0};
        foreach (tbl[i]) begin
            start = tbl[i].st; abort = tbl[i].ab; hdmi_vs = tbl[i].vs;
            hdmi_de = tbl[i].de; wr_ready = tbl[i].rdy;
            {hdmi_r, hdmi_g, hdmi_b} = 24'($urandom);
            tick;
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d_valid", i), 32'(wr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d_addr", i), 32'(wr_addr), 0);
        end
        start = 0; abort = 0; hdmi_de = 0; hdmi_vs = 1;
        tick;

        run_frame("full", TOTAL, 0, 0);
        run_frame("backpressure", TOTAL, 1, 0);
        chk("backpressure_kept", wa.size(), TOTAL - 4);
        run_frame("stall", TOTAL, 2, 0);
        run_frame("short", 20, 0, 0);
        chk("short_writes", wa.size(), 20);

        done_cnt = 0;
        wr_ready = 1; start = 1; tick; start = 0;
        hdmi_vs = 0; tick; hdmi_vs = 1;
        for (int i = 0; i < 10; i++) begin
            {hdmi_r, hdmi_g, hdmi_b} = 24'($urandom);
            hdmi_de = 1;
            tick;
        end
        abort = 1; tick; abort = 0; hdmi_de = 0;
        chk("abort_valid", 32'(wr_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        for (int i = 0; i < 5; i++) tick;
        chk("abort_done", done_cnt, 0);
        run_frame("after_abort", TOTAL, 0, 0);

        for (int k = 0; k < 6; k++)
            run_frame($sformatf("random%0d", k), k < 3 ? TOTAL : $urandom_range(5, 30), 3, 1);

        wr_ready = 0; start = 1; tick; start = 0;
        hdmi_vs = 0; tick; hdmi_vs = 1;
        for (int i = 0; i < TOTAL; i++) begin
            {hdmi_r, hdmi_g, hdmi_b} = 24'($urandom);
            hdmi_de = 1;
            tick;
        end
        hdmi_de = 0; tick;
        chk("drain_busy", 32'(busy), 1);
        chk("drain_valid", 32'(wr_valid), 1);
        chk("drain_overflow", 32'(overflow), 1);
        #3 rst_n = 0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_valid", 32'(wr_valid), 0);
        chk("async_done", 32'(done), 0);
        chk("async_overflow", 32'(overflow), 0);
        chk("async_frame_err", 32'(frame_err), 0);
        chk("async_addr", 32'(wr_addr), 0);
        wa.delete();
        tick;
        rst_n = 1; wr_ready = 1;
        for (int i = 0; i < 5; i++) tick;
        chk("post_reset_writes", wa.size(), 0);
        chk("post_reset_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
